mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Parametrised, handshaked successor of the single-cycle memory stage. It takes one instruction per transaction from EX and computes the writeback-side result (pc+4 / pc+imm / imm / ALU pass-through). For loads and stores it drives a req/gnt/rvalid data-memory port with byte enables, lane alignment, sign/zero extension and misalignment/illegal-op faulting. It sits between EX and WB and tolerates any memory latency, back-pressuring EX through `in_ready`.

## Interface
- `BUS_WIDTH`, 64: datapath width; legal values 32 or 64. `NB = BUS_WIDTH/8`.
- `INSTR_WIDTH`, 32: instruction width; only funct3 is consumed.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: EX presents an instruction.
- `in_ready` out 1: stage accepts; transfer when `in_valid & in_ready`.
- `mem_read`, `mem_write`, `jalr_src`, `u_src`, `uj_src` in 1 each: control, sampled at transfer.
- `funct3` in 3: load/store size and signedness.
- `alu_fpu_result`, `mem_in`, `imm`, `pc` in BUS_WIDTH: address/ALU result, store data, immediate, PC.
- `out_valid` out 1: result available to WB.
- `out_ready` in 1: WB consumes when `out_valid & out_ready`.
- `write_data` out BUS_WIDTH: non-load result.
- `mem_out` out BUS_WIDTH: extended load data; 0 for non-loads and faults.
- `lsu_fault` out 1: misaligned or illegal access; no memory access performed.
- `dmem_req` out 1: memory request; held until granted.
- `dmem_gnt` in 1: memory accepts the request this cycle.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out BUS_WIDTH: `alu_fpu_result` with low log2(NB) bits cleared.
- `dmem_wdata` out BUS_WIDTH: store data replicated across lanes.
- `dmem_be` out NB: byte enables; all ones for loads.
- `dmem_rdata` in BUS_WIDTH: read data.
- `dmem_rvalid` in 1: read data valid; one pulse per granted load.

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE.
- `in_ready` = (state == IDLE).
- IDLE, on transfer, registers all inputs and `write_data = uj_src ? (jalr_src ? pc+4 : alu_fpu_result) : (u_src ? pc+imm : imm)`, all modulo 2^BUS_WIDTH. Next state:
  - neither read nor write: DONE.
  - fault: DONE, with `lsu_fault=1` and `mem_out=0`.
  - otherwise: REQ.
- Fault conditions (any one):
  - `mem_read & mem_write`.
  - load with funct3 = 111.
  - store with funct3[2] = 1.
  - 64-bit access (funct3 011 or 110) when BUS_WIDTH = 32.
  - address not aligned to access size (half: bit0; word: bits1:0; dword: bits2:0).
- REQ: `dmem_req=1`. On `dmem_gnt`, a store goes to DONE and a load goes to WAIT_R.
- WAIT_R: on `dmem_rvalid`, select the byte lane at address offset and extend. Signed for funct3 000/001/010; zero for 100/101/110; 011 takes the full lane. Register the result into `mem_out`, then go to DONE.
- DONE: `out_valid=1`. On `out_ready`, go to IDLE. Outputs hold stable while stalled.
- Store `dmem_be` sets size bits starting at the offset byte. `dmem_wdata` replicates `mem_in[size-1:0]` across lanes.
- `dmem_rvalid` outside WAIT_R is ignored.

## Timing
- Reset (async assert): state IDLE. `out_valid`, `dmem_req`, `dmem_we`, `lsu_fault` = 0. `write_data`, `mem_out`, `dmem_addr`, `dmem_wdata`, `dmem_be` = 0. `in_ready` = 1 after reset.
- Reset mid-transaction drops the op immediately: `dmem_req` falls combinationally with `rst_n`, and no output is produced.
- All outputs are registered or pure decodes of registered state. There is no combinational path from `dmem_*` or `out_ready` inputs to outputs.
- Accepted in cycle N:
  - non-memory or fault: `out_valid` in N+1.
  - store: `dmem_req` in N+1, `out_valid` one cycle after grant (N+2 with same-cycle grant).
  - load: `out_valid` one cycle after `dmem_rvalid` (earliest N+3).
- `dmem_req`, `dmem_addr`, `dmem_we`, `dmem_wdata`, `dmem_be` are stable from REQ entry until grant.
- Back-to-back throughput: one op per 2 cycles minimum, because of the DONE→IDLE turnaround.

## Test plan
- **ALU pass-through:** `uj_src=1`, `jalr_src=0`, `alu_fpu_result=0x1234`, `out_ready=1` -> `out_valid` next cycle, `write_data=0x1234`, `mem_out=0`, no `dmem_req`.
- **JAL link:** `uj_src=1`, `jalr_src=1`, `pc=0x100` -> `write_data=0x104`. Also `u_src=1`, `imm=0x2000` -> `write_data=0x2100`.
- **Signed load with latency:** `lh` at addr 0x1006, memory grants after 2 cycles and returns `rdata=0x8001_0000_0000_0000` 3 cycles later -> `dmem_addr=0x1000`, `mem_out=0xFFFF_FFFF_FFFF_8001`. `lhu` at the same address -> `0x8001`.
- **Byte store:** `sb` addr 0x203, `mem_in=0xAB` -> `dmem_be=0x08`, `dmem_wdata=0xABAB_ABAB_ABAB_ABAB`, `dmem_we=1`, held until `dmem_gnt`.
- **Faults:** `lw` at 0x102, then a store with funct3=100, then `mem_read=mem_write=1` -> each gives `lsu_fault=1`, `mem_out=0`, no `dmem_req`, `out_valid` after 1 cycle.
- **Stall and reset:** hold `out_ready=0` for 5 cycles -> outputs stable and `in_ready=0`. Deassert `rst_n` while in WAIT_R -> all outputs 0 immediately; a later stray `dmem_rvalid` produces no `out_valid`.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Handshaked memory stage: computes the writeback value for every op and runs
// loads/stores over a req/gnt/rvalid data port with alignment and fault checks.
module mem_stage_lsu #(
    parameter int BUS_WIDTH   = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic                     jalr_src,
    input  logic                     u_src,
    input  logic                     uj_src,
    input  logic [2:0]               funct3,
    input  logic [BUS_WIDTH-1:0]     alu_fpu_result,
    input  logic [BUS_WIDTH-1:0]     mem_in,
    input  logic [BUS_WIDTH-1:0]     imm,
    input  logic [BUS_WIDTH-1:0]     pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BUS_WIDTH-1:0]     write_data,
    output logic [BUS_WIDTH-1:0]     mem_out,
    output logic                     lsu_fault,
    output logic                     dmem_req,
    input  logic                     dmem_gnt,
    output logic                     dmem_we,
    output logic [BUS_WIDTH-1:0]     dmem_addr,
    output logic [BUS_WIDTH-1:0]     dmem_wdata,
    output logic [BUS_WIDTH/8-1:0]   dmem_be,
    input  logic [BUS_WIDTH-1:0]     dmem_rdata,
    input  logic                     dmem_rvalid
);
    localparam int NB   = BUS_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam logic [BUS_WIDTH-1:0] PC_STEP = BUS_WIDTH'(4);

    if ((BUS_WIDTH != 32 && BUS_WIDTH != 64) || INSTR_WIDTH < 32) begin : g_param_check
        $error("mem_stage_lsu: unsupported BUS_WIDTH or INSTR_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic access_fault(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [OFFW-1:0] off);
        logic       bad_op;
        logic       misaligned;
        logic [2:0] off3;
        off3   = 3'(off);
        bad_op = (rd & wr) | (rd & (f3 == 3'b111)) | (wr & f3[2])
               | ((BUS_WIDTH == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
        case (f3[1:0])
            2'b01:   misaligned = off3[0];
            2'b10:   misaligned = |off3[1:0];
            2'b11:   misaligned = |off3;
            default: misaligned = 1'b0;
        endcase
        return (rd | wr) & (bad_op | misaligned);
    endfunction

    function automatic logic [NB-1:0] store_be(input logic [1:0] size, input logic [OFFW-1:0] off);
        logic [7:0] mask;
        case (size)
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            2'b10:   mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return NB'(mask) << off;
    endfunction

    function automatic logic [BUS_WIDTH-1:0] replicate(input logic [BUS_WIDTH-1:0] d, input logic [1:0] size);
        logic [BUS_WIDTH-1:0] rep;
        case (size)
            2'b00:   rep = {NB{d[7:0]}};
            2'b01:   rep = {(NB/2){d[15:0]}};
            2'b10:   rep = {(NB/4){d[31:0]}};
            default: rep = d;
        endcase
        return rep;
    endfunction

    // Shift the addressed lane to bit 0, then push it to the top and back down
    // so one arithmetic/logical shift pair handles every size and signedness.
    function automatic logic [BUS_WIDTH-1:0] extend_load(input logic [BUS_WIDTH-1:0] rdata,
                                                         input logic [OFFW-1:0] off,
                                                         input logic [2:0] f3);
        logic [BUS_WIDTH-1:0] lane;
        logic [6:0]           sh;
        lane = rdata >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   sh = 7'(BUS_WIDTH - 8);
            2'b01:   sh = 7'(BUS_WIDTH - 16);
            2'b10:   sh = 7'(BUS_WIDTH - 32);
            default: sh = 7'd0;
        endcase
        lane = lane << sh;
        return f3[2] ? (lane >> sh) : BUS_WIDTH'($signed(lane) >>> sh);
    endfunction

    state_t               state_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [BUS_WIDTH-1:0] write_data_r;
    logic [BUS_WIDTH-1:0] mem_out_r;
    logic                 lsu_fault_r;
    logic                 dmem_req_r;
    logic                 dmem_we_r;
    logic [BUS_WIDTH-1:0] dmem_addr_r;
    logic [BUS_WIDTH-1:0] dmem_wdata_r;
    logic [NB-1:0]        dmem_be_r;
    logic [2:0]           funct3_r;
    logic [OFFW-1:0]      off_r;

    logic [OFFW-1:0]      off_s;
    logic                 fault_s;
    logic                 mem_access_s;
    logic [BUS_WIDTH-1:0] wd_s;
    logic [BUS_WIDTH-1:0] addr_s;
    logic [BUS_WIDTH-1:0] wdata_s;
    logic [NB-1:0]        be_s;

    // Decode of the instruction presented by EX
    always_comb begin
        off_s        = alu_fpu_result[OFFW-1:0];
        fault_s      = access_fault(mem_read, mem_write, funct3, off_s);
        mem_access_s = (mem_read | mem_write) & ~fault_s;
        wd_s         = uj_src ? (jalr_src ? pc + PC_STEP : alu_fpu_result)
                              : (u_src ? pc + imm : imm);
        addr_s       = {alu_fpu_result[BUS_WIDTH-1:OFFW], {OFFW{1'b0}}};
        wdata_s      = replicate(mem_in, funct3[1:0]);
        be_s         = mem_access_s ? (mem_read ? {NB{1'b1}} : store_be(funct3[1:0], off_s))
                                    : {NB{1'b0}};
    end

    // Transaction FSM; every output is a flop updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            write_data_r <= {BUS_WIDTH{1'b0}};
            mem_out_r    <= {BUS_WIDTH{1'b0}};
            lsu_fault_r  <= 1'b0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= {BUS_WIDTH{1'b0}};
            dmem_wdata_r <= {BUS_WIDTH{1'b0}};
            dmem_be_r    <= {NB{1'b0}};
            funct3_r     <= 3'b000;
            off_r        <= {OFFW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        write_data_r <= wd_s;
                        mem_out_r    <= {BUS_WIDTH{1'b0}};
                        lsu_fault_r  <= fault_s;
                        dmem_addr_r  <= addr_s;
                        dmem_wdata_r <= wdata_s;
                        dmem_be_r    <= be_s;
                        dmem_we_r    <= mem_write & ~fault_s;
                        funct3_r     <= funct3;
                        off_r        <= off_s;
                        in_ready_r   <= 1'b0;
                        if (mem_access_s) begin
                            state_r    <= REQ;
                            dmem_req_r <= 1'b1;
                        end else begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req_r <= 1'b0;
                        if (dmem_we_r) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= WAIT_R;
                        end
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT_R: begin
                    if (dmem_rvalid) begin
                        mem_out_r   <= extend_load(dmem_rdata, off_r, funct3_r);
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r <= WAIT_R;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    dmem_req_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign write_data = write_data_r;
    assign mem_out    = mem_out_r;
    assign lsu_fault  = lsu_fault_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_wdata = dmem_wdata_r;
    assign dmem_be    = dmem_be_r;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu (BUS_WIDTH=64) with a scripted memory responder.
module tb_mem_stage_lsu;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        mem_read, mem_write, jalr_src, u_src, uj_src;
    logic [2:0]  funct3;
    logic [63:0] alu_fpu_result, mem_in, imm, pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] write_data, mem_out;
    logic        lsu_fault;
    logic        dmem_req, dmem_gnt, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_be;
    logic        dmem_rvalid;

    typedef struct {
        string       tag;
        logic [63:0] wd;
        logic [63:0] mo;
        logic        f;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_stage_lsu #(.BUS_WIDTH(64), .INSTR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mem_read(mem_read), .mem_write(mem_write), .jalr_src(jalr_src),
        .u_src(u_src), .uj_src(uj_src), .funct3(funct3),
        .alu_fpu_result(alu_fpu_result), .mem_in(mem_in), .imm(imm), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .write_data(write_data),
        .mem_out(mem_out), .lsu_fault(lsu_fault), .dmem_req(dmem_req),
        .dmem_gnt(dmem_gnt), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_rvalid(dmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every result WB consumes against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_out", 64'(out_valid), 64'h0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq({mon_e.tag, "_write_data"}, write_data, mon_e.wd);
                check_eq({mon_e.tag, "_mem_out"}, mem_out, mon_e.mo);
                check_eq({mon_e.tag, "_fault"}, 64'(lsu_fault), 64'(mon_e.f));
            end
        end
    end

    task automatic run_op(input string tag, input logic rd, input logic wr, input logic jalr,
                          input logic u, input logic uj, input logic [2:0] f3,
                          input logic [63:0] alu, input logic [63:0] din, input logic [63:0] im,
                          input logic [63:0] p, input int gdly, input int rdly,
                          input logic [63:0] rdata, input int stall,
                          input logic [63:0] exp_wd, input logic [63:0] exp_mo, input logic exp_f,
                          input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                          input logic [7:0] exp_be);
        exp_t e;
        logic mem_op;
        mem_op = (rd | wr) & ~exp_f;
        @(posedge clk); #1;
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'h1);
        out_ready = (stall == 0);
        mem_read = rd; mem_write = wr; jalr_src = jalr; u_src = u; uj_src = uj;
        funct3 = f3; alu_fpu_result = alu; mem_in = din; imm = im; pc = p;
        in_valid = 1'b1;
        e.tag = tag; e.wd = exp_wd; e.mo = exp_mo; e.f = exp_f;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (mem_op) begin
            check_eq({tag, "_req"}, 64'(dmem_req), 64'h1);
            check_eq({tag, "_we"}, 64'(dmem_we), 64'(wr));
            check_eq({tag, "_addr"}, dmem_addr, exp_addr);
            check_eq({tag, "_be"}, 64'(dmem_be), 64'(exp_be));
            if (wr) check_eq({tag, "_wdata"}, dmem_wdata, exp_wdata);
            for (int i = 0; i < gdly; i++) begin
                @(posedge clk); #1;
                check_eq({tag, "_req_hold"}, 64'(dmem_req), 64'h1);
                check_eq({tag, "_addr_hold"}, dmem_addr, exp_addr);
                check_eq({tag, "_be_hold"}, 64'(dmem_be), 64'(exp_be));
                if (wr) check_eq({tag, "_wdata_hold"}, dmem_wdata, exp_wdata);
            end
            dmem_gnt = 1'b1;
            @(posedge clk); #1;
            dmem_gnt = 1'b0;
            check_eq({tag, "_req_drop"}, 64'(dmem_req), 64'h0);
            if (!wr) begin
                for (int i = 0; i < rdly; i++) begin
                    @(posedge clk); #1;
                    check_eq({tag, "_early_valid"}, 64'(out_valid), 64'h0);
                end
                dmem_rdata  = rdata;
                dmem_rvalid = 1'b1;
                @(posedge clk); #1;
                dmem_rvalid = 1'b0;
                dmem_rdata  = 64'h0;
            end
        end else begin
            check_eq({tag, "_no_req"}, 64'(dmem_req), 64'h0);
        end
        check_eq({tag, "_latency"}, 64'(out_valid), 64'h1);
        for (int i = 0; i < stall; i++) begin
            check_eq({tag, "_stall_valid"}, 64'(out_valid), 64'h1);
            check_eq({tag, "_stall_in_ready"}, 64'(in_ready), 64'h0);
            check_eq({tag, "_stall_wd"}, write_data, exp_wd);
            check_eq({tag, "_stall_mo"}, mem_out, exp_mo);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (sb_q.size() != 0) begin
            check_eq({tag, "_drain_timeout"}, 64'(sb_q.size()), 64'h0);
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; jalr_src = 1'b0; u_src = 1'b0; uj_src = 1'b0;
        funct3 = 3'b000; alu_fpu_result = 64'h0; mem_in = 64'h0; imm = 64'h0; pc = 64'h0;
        dmem_gnt = 1'b0; dmem_rdata = 64'h0; dmem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'h1);
        check_eq("rst_out_valid", 64'(out_valid), 64'h0);
        check_eq("rst_req", 64'(dmem_req), 64'h0);
        check_eq("rst_write_data", write_data, 64'h0);
        check_eq("rst_be", 64'(dmem_be), 64'h0);
        rst_n = 1'b1;

        //      tag      rd    wr    jalr  u     uj    f3      alu                    din                    imm                    pc                     g  r  rdata                  st expected wd          expected mo            f     addr         wdata                  be
        run_op("alu",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 64'h1234,              64'h0,                 64'h0,                 64'h0,                 0, 0, 64'h0,                 0, 64'h1234,              64'h0,                 1'b0, 64'h0,       64'h0,                 8'h00);
        run_op("jal",   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 64'h0,                 64'h0,                 64'h0,                 64'h100,               0, 0, 64'h0,                 0, 64'h104,               64'h0,                 1'b0, 64'h0,       64'h0,                 8'h00);
        run_op("auipc", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 64'h0,                 64'h0,                 64'h2000,              64'h100,               0, 0, 64'h0,                 0, 64'h2100,              64'h0,                 1'b0, 64'h0,       64'h0,                 8'h00);
        run_op("lui",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'h0,                 64'h0,                 64'hDEAD_0000,         64'h100,               0, 0, 64'h0,                 0, 64'hDEAD_0000,         64'h0,                 1'b0, 64'h0,       64'h0,                 8'h00);
        run_op("wrap",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 64'h0,                 64'h0,                 64'h8,                 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0,               0, 64'h4,                 64'h0,                 1'b0, 64'h0,       64'h0,                 8'h00);
        run_op("lh",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 64'h1006,              64'h0,                 64'h0,                 64'h0,                 2, 3, 64'h8001_0000_0000_0000, 0, 64'h0,               64'hFFFF_FFFF_FFFF_8001, 1'b0, 64'h1000, 64'h0,                 8'hFF);
        run_op("lhu",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 64'h1006,              64'h0,                 64'h0,                 64'h0,                 2, 3, 64'h8001_0000_0000_0000, 0, 64'h0,               64'h8001,              1'b0, 64'h1000,    64'h0,                 8'hFF);
        run_op("lb",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'h1001,              64'h0,                 64'h0,                 64'h0,                 0, 0, 64'h0000_0000_0000_F200, 0, 64'h0,               64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 64'h1000, 64'h0,                 8'hFF);
        run_op("lw",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 64'h1004,              64'h0,                 64'h0,                 64'h0,                 1, 1, 64'h8765_4321_0000_0000, 0, 64'h0,               64'hFFFF_FFFF_8765_4321, 1'b0, 64'h1000, 64'h0,                 8'hFF);
        run_op("lwu",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 64'h1004,              64'h0,                 64'h0,                 64'h0,                 0, 2, 64'h8765_4321_0000_0000, 0, 64'h0,               64'h8765_4321,         1'b0, 64'h1000,    64'h0,                 8'hFF);
        run_op("ld",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 64'h1000,              64'h0,                 64'h0,                 64'h0,                 0, 0, 64'h0123_4567_89AB_CDEF, 0, 64'h0,               64'h0123_4567_89AB_CDEF, 1'b0, 64'h1000, 64'h0,                 8'hFF);
        run_op("sb",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 64'h203,               64'hAB,                64'h0,                 64'h0,                 3, 0, 64'h0,                 0, 64'h0,                 64'h0,                 1'b0, 64'h200,     64'hABAB_ABAB_ABAB_ABAB, 8'h08);
        run_op("sh",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 64'h206,               64'h1234_BEEF,         64'h0,                 64'h0,                 0, 0, 64'h0,                 0, 64'h0,                 64'h0,                 1'b0, 64'h200,     64'hBEEF_BEEF_BEEF_BEEF, 8'hC0);
        run_op("sw",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 64'h204,               64'hCAFE_BABE,         64'h0,                 64'h0,                 1, 0, 64'h0,                 0, 64'h0,                 64'h0,                 1'b0, 64'h200,     64'hCAFE_BABE_CAFE_BABE, 8'hF0);
        run_op("sd",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 64'h208,               64'h0123_4567_89AB_CDEF, 64'h0,               64'h0,                 0, 0, 64'h0,                 0, 64'h0,                 64'h0,                 1'b0, 64'h208,     64'h0123_4567_89AB_CDEF, 8'hFF);
        run_op("f_lw",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 64'h102,               64'h0,                 64'h77,                64'h0,                 0, 0, 64'h0,                 0, 64'h77,                64'h0,                 1'b1, 64'h0,       64'h0,                 8'h00);
        run_op("f_st4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 64'h200,               64'h55,                64'h77,                64'h0,                 0, 0, 64'h0,                 0, 64'h77,                64'h0,                 1'b1, 64'h0,       64'h0,                 8'h00);
        run_op("f_rw",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 64'h200,               64'h55,                64'h77,                64'h0,                 0, 0, 64'h0,                 0, 64'h77,                64'h0,                 1'b1, 64'h0,       64'h0,                 8'h00);
        run_op("f_ld",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 64'h1004,              64'h0,                 64'h77,                64'h0,                 0, 0, 64'h0,                 0, 64'h77,                64'h0,                 1'b1, 64'h0,       64'h0,                 8'h00);
        run_op("f_l7",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 64'h1000,              64'h0,                 64'h77,                64'h0,                 0, 0, 64'h0,                 0, 64'h77,                64'h0,                 1'b1, 64'h0,       64'h0,                 8'h00);
        run_op("stall", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 64'h0,                 64'h0,                 64'h0,                 64'h2000,              0, 0, 64'h0,                 5, 64'h2004,              64'h0,                 1'b0, 64'h0,       64'h0,                 8'h00);

        // Reset while a store request is pending: request drops at once
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010; alu_fpu_result = 64'h300;
        mem_in = 64'h1111; uj_src = 1'b0; u_src = 1'b0; imm = 64'h99; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("rreq_req", 64'(dmem_req), 64'h1);
        rst_n = 1'b0; #1;
        check_eq("rreq_req_drop", 64'(dmem_req), 64'h0);
        check_eq("rreq_we_drop", 64'(dmem_we), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset while waiting for read data, then a stray rvalid
        @(posedge clk); #1;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_fpu_result = 64'h1008;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        check_eq("rwait_in_ready", 64'(in_ready), 64'h0);
        rst_n = 1'b0; #1;
        check_eq("rwait_out_valid", 64'(out_valid), 64'h0);
        check_eq("rwait_write_data", write_data, 64'h0);
        check_eq("rwait_mem_out", mem_out, 64'h0);
        check_eq("rwait_addr", dmem_addr, 64'h0);
        check_eq("rwait_be", 64'(dmem_be), 64'h0);
        check_eq("rwait_wdata", dmem_wdata, 64'h0);
        check_eq("rwait_fault", 64'(lsu_fault), 64'h0);
        check_eq("rwait_in_ready_rst", 64'(in_ready), 64'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; dmem_rvalid = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("stray_out_valid", 64'(out_valid), 64'h0);
            check_eq("stray_in_ready", 64'(in_ready), 64'h1);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
